count_monitor: RTL

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/count_monitor.sv
// count_monitor: watches a 4-bit up/down counter and reports step direction,
// wrap events (15->0 up, 0->15 down), illegal steps and a compare match.
// An illegal step latches the FAULT state until Clr.
// Optional feature: define COUNT_MONITOR_ERRCNT_EN to build the saturating
// illegal-step counter on ErrCnt; otherwise ErrCnt is tied to 0.
module count_monitor #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [3:0]        Count,
  input  logic [3:0]        Cmp,
  input  logic              Clr,
  output logic              Dir,
  output logic              WrapUp,
  output logic              WrapDn,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Err,
  output logic              Fault,
  output logic              Match,
  output logic [7:0]        ErrCnt
);

  typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

  state_e              state_q, state_d;
  logic [3:0]          prev_q;
  logic                dir_q, dir_d;
  logic                wrap_up_q, wrap_up_d;
  logic                wrap_dn_q, wrap_dn_d;
  logic                err_q, err_d;
  logic                fault_q;
  logic                match_q;
  logic [WRAP_W-1:0]   wraps_q, wraps_d;
  logic [3:0]          delta;

  // Step size modulo 16 between this sample and the previous one
  assign delta = Count - prev_q;

  // Next-state, direction, wrap and error evaluation; Clr overrides the step
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    wraps_d   = wraps_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    err_d     = 1'b0;
    if (Clr) begin
      state_d = StIdle;
      dir_d   = 1'b0;
      wraps_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StTrack;  // this edge only primes prev_q
        StTrack: begin
          if (delta == 4'd1) begin
            dir_d = 1'b1;
            if (prev_q == 4'd15) begin
              wrap_up_d = 1'b1;
              if (wraps_q != {WRAP_W{1'b1}}) wraps_d = wraps_q + WRAP_W'(1);
            end
          end else if (delta == 4'd15) begin
            dir_d = 1'b0;
            if (prev_q == 4'd0) begin
              wrap_dn_d = 1'b1;
              if (wraps_q != {WRAP_W{1'b1}}) wraps_d = wraps_q + WRAP_W'(1);
            end
          end else if (delta != 4'd0) begin
            err_d   = 1'b1;
            state_d = StFault;
          end
        end
        StFault: state_d = StFault;  // held until Clr
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers; prev_q and match_q sample every edge
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      prev_q    <= 4'd0;
      dir_q     <= 1'b0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      err_q     <= 1'b0;
      fault_q   <= 1'b0;
      match_q   <= 1'b0;
      wraps_q   <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= Count;
      dir_q     <= dir_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      err_q     <= err_d;
      fault_q   <= (state_d == StFault);
      match_q   <= (Count == Cmp);
      wraps_q   <= wraps_d;
    end
  end

`ifdef COUNT_MONITOR_ERRCNT_EN
  logic [7:0] errcnt_q;

  // Saturating count of illegal steps, cleared by Clr
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      errcnt_q <= 8'd0;
    end else if (Clr) begin
      errcnt_q <= 8'd0;
    end else if (err_d && errcnt_q != 8'hff) begin
      errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign ErrCnt = errcnt_q;
`else
  assign ErrCnt = 8'd0;
`endif

  assign Dir    = dir_q;
  assign WrapUp = wrap_up_q;
  assign WrapDn = wrap_dn_q;
  assign Wraps  = wraps_q;
  assign Err    = err_q;
  assign Fault  = fault_q;
  assign Match  = match_q;

endmodule
